fir_sample_sequencer: RTL and testbench
=======================================

# fir_sample_sequencer

Sample-rate sequencer for the pipelined FIR datapath. It derives the audio sample strobe (44.1 kHz nominal) from the 50 MHz system clock with a phase accumulator, pulls one input sample per strobe from an upstream valid/ready source, issues it to the FIR core when the core reports ready-for-data, and collects FIR results into a small output FIFO. It guarantees the output FIFO can never overflow by limiting in-flight samples with a credit counter.

## Interface
- `DW`, 16, sample width (input and output).
- `PHASE_W`, 24, phase accumulator width.
- `PHASE_INC`, 14797, accumulator increment per clock (44100/50e6 × 2^24).
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  run request; low stops new issues and drains.
- `in_data`  in  DW  upstream sample.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  holding register can accept.
- `fir_din`  out  DW  sample to FIR core.
- `fir_nd`  out  1  one-cycle new-data strobe to FIR core.
- `fir_rfd`  in  1  FIR core ready for data.
- `fir_rdy`  in  1  FIR result valid (one cycle per result).
- `fir_dout`  in  DW  FIR result.
- `out_data`  out  DW  FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream accepts head.
- `busy`  out  1  state ≠ IDLE.
- `missed_tick_cnt`  out  16  saturating count of sample strobes that found an unserviced pending strobe.

## Operation
- States: IDLE, RUN, DRAIN. IDLE→RUN when `enable`=1. RUN→DRAIN when `enable`=0 and outstanding>0; RUN→IDLE when `enable`=0 and outstanding=0. DRAIN→IDLE when outstanding=0; `enable` in DRAIN is ignored until IDLE.
- Accumulator: in RUN, acc ← acc+PHASE_INC mod 2^PHASE_W; carry-out registered as `tick` (1-cycle pulse). In IDLE/DRAIN acc and `tick` are held at 0.
- Pending: `tick` sets `pending`. Issue clears it. If `tick` and issue occur in the same cycle, `pending` stays 1. If `tick` arrives while `pending`=1 and no issue occurs that cycle, `missed_tick_cnt` increments (saturating at 0xFFFF) and `pending` stays 1.
- Holding register: one entry. `in_ready` = !hold_valid || issue. A transfer occurs when `in_valid`&&`in_ready`.
- Issue condition (combinational): state=RUN && pending && hold_valid && `fir_rfd` && (outstanding+fifo_count < FIFO_DEPTH).
- On issue: `fir_din` ← hold and `fir_nd` ← 1 at the next edge. `fir_din` holds its value until the next issue. Outstanding is incremented.
- On `fir_rdy` with outstanding>0: `fir_dout` is written to the FIFO and outstanding is decremented. If issue and `fir_rdy` occur in the same cycle, outstanding is unchanged. `fir_rdy` with outstanding=0 is ignored: no write and no decrement.
- FIFO: first-word fall-through. Pop on `out_valid`&&`out_ready`. Simultaneous push and pop is allowed at any fill level, including full, because credit guarantees a push never targets a full FIFO without a pop.
- Counter widths: outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: state=IDLE, acc=0, `tick`=0, `pending`=0, `fir_nd`=0, `fir_din`=0, hold_valid=0, `in_ready`=1, FIFO empty, `out_valid`=0, `out_data`=0, outstanding=0, `busy`=0, `missed_tick_cnt`=0.
- Tick latency: the carry at edge k produces `tick`=1 in cycle k+1. The earliest `fir_nd` follows at edge k+2.
- Input-to-FIR latency: 1 cycle from the issue condition to `fir_nd`.
- FIR-result-to-output latency: a result written on the edge where `fir_rdy`=1 appears with `out_valid`=1 in the next cycle.
- Reset mid-operation clears all state immediately. In-flight FIR results arriving after reset are ignored, because outstanding is 0.

## Configuration
- `FIR_SEQ_STATS_EN` defined: `missed_tick_cnt` is implemented as above.
- `FIR_SEQ_STATS_EN` undefined: `missed_tick_cnt` is tied to 0, and the counter logic is not built. All other behaviour is identical.

## Test plan
- **Basic flow.** PHASE_W=24, PHASE_INC=2^22 (tick every 4 cycles), source always valid with values 1,2,3…, FIR model fixed 5-cycle latency. Required: `fir_nd` every 4 cycles, `fir_din` sequence 1,2,3, outputs in the same order, `missed_tick_cnt`=0.
- **Rfd stall and missed ticks.** Hold `fir_rfd`=0 for 10 cycles in RUN. Required: no `fir_nd` during the stall, `missed_tick_cnt`=2 (with stats enabled), and one issue within 1 cycle of `fir_rfd` rising.
- **Credit limit.** Hold `out_ready`=0 with FIFO_DEPTH=4. Required: exactly 4 issues, then `fir_nd` stays 0. After releasing `out_ready` for one pop, exactly one further issue.
- **Drain.** Deassert `enable` with 3 samples outstanding. Required: state DRAIN, no new `fir_nd`, all 3 results land in the FIFO, then IDLE with `busy`=0.
- **Async reset.** Assert `rst_n`=0 with outstanding=2 and the FIFO holding 1 entry. Required: all outputs at reset values immediately. After release, a stray `fir_rdy` pulse is not written to the FIFO.
- **Simultaneous events.** Apply issue and `fir_rdy` in the same cycle. Required: outstanding is unchanged. Apply tick and issue in the same cycle. Required: `pending` stays 1 and the missed count is unchanged.

Source files
------------

// File: rtl/fir_sample_sequencer.sv
// Sample-rate sequencer: phase-accumulator strobe, one-entry input hold, FIR issue with
// credit-limited in-flight count, FWFT result FIFO. Define FIR_SEQ_STATS_EN for missed_tick_cnt.
module fir_sample_sequencer #(
    parameter int DW         = 16,
    parameter int PHASE_W    = 24,
    parameter int PHASE_INC  = 14797,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] fir_din,
    output logic          fir_nd,
    input  logic          fir_rfd,
    input  logic          fir_rdy,
    input  logic [DW-1:0] fir_dout,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic [15:0]   missed_tick_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [PHASE_W:0] INC_C = (PHASE_W+1)'(PHASE_INC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   acc_sum;
    logic               tick;
    logic               pending;
    logic [DW-1:0]      hold;
    logic               hold_valid;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        credit_used;
    logic [AW-1:0]      wptr, rptr;
    logic [DW-1:0]      mem [FIFO_DEPTH];
    logic               issue, xfer, fifo_wr, fifo_rd;

    assign acc_sum     = {1'b0, acc} + INC_C;
    // Results already in the FIFO plus those still inside the core must fit in the FIFO.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign issue       = (state == RUN) && pending && hold_valid && fir_rfd && (credit_used < DEPTH_C);
    assign in_ready    = !hold_valid || issue;
    assign xfer        = in_valid && in_ready;
    assign fifo_wr     = fir_rdy && (outstanding != '0);
    assign fifo_rd     = out_valid && out_ready;
    assign out_valid   = (fifo_count != '0);
    assign out_data    = out_valid ? mem[rptr] : '0;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                // A same-cycle issue still leaves a result to collect.
                RUN:     if (!enable) state <= ((outstanding != '0) || issue) ? DRAIN : IDLE;
                DRAIN:   if (outstanding == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            tick    <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (state == RUN) begin
                {tick, acc} <= acc_sum;
            end else begin
                acc  <= '0;
                tick <= 1'b0;
            end
            if (tick)       pending <= 1'b1;
            else if (issue) pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold        <= '0;
            hold_valid  <= 1'b0;
            fir_nd      <= 1'b0;
            fir_din     <= '0;
            outstanding <= '0;
        end else begin
            if (xfer) begin
                hold       <= in_data;
                hold_valid <= 1'b1;
            end else if (issue) begin
                hold_valid <= 1'b0;
            end
            fir_nd <= issue;
            if (issue) fir_din <= hold;
            if (issue && !fifo_wr)      outstanding <= outstanding + 1'b1;
            else if (!issue && fifo_wr) outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wptr <= wptr + 1'b1;
            if (fifo_rd) rptr <= rptr + 1'b1;
            if (fifo_wr && !fifo_rd)      fifo_count <= fifo_count + 1'b1;
            else if (fifo_rd && !fifo_wr) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wptr] <= fir_dout;
    end

`ifdef FIR_SEQ_STATS_EN
    logic [15:0] missed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed_q <= '0;
        end else if (tick && pending && !issue && (missed_q != 16'hFFFF)) begin
            missed_q <= missed_q + 1'b1;
        end
    end

    assign missed_tick_cnt = missed_q;
`else
    assign missed_tick_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Scoreboard bench for fir_sample_sequencer: directed phases with a fixed-latency FIR core model.
module tb_fir_sample_sequencer;
    localparam int DW = 16, PW = 24, PINC = 1 << 22, FD = 4;
`ifdef FIR_SEQ_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk, rst_n, enable, in_valid, in_ready, fir_nd, fir_rfd, fir_rdy;
    logic out_valid, out_ready, busy, stray_rdy;
    logic [DW-1:0] in_data, fir_din, fir_dout, out_data;
    logic [15:0] missed_tick_cnt;

    fir_sample_sequencer #(.DW(DW), .PHASE_W(PW), .PHASE_INC(PINC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fir_din(fir_din), .fir_nd(fir_nd), .fir_rfd(fir_rfd),
        .fir_rdy(fir_rdy), .fir_dout(fir_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .missed_tick_cnt(missed_tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, nd_cnt = 0, pop_cnt = 0, last_nd = -1;
    bit chk_sp = 0;
    logic [DW-1:0] issue_q[$], result_q[$];

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fir_f(input logic [DW-1:0] x);
        return DW'(32'(x) * 3 + 7);
    endfunction

    always @(posedge clk) cyc++;

    // Upstream source: always valid, values 1,2,3,...
    initial begin
        logic xf;
        in_data = 1;
        forever begin
            @(negedge clk);
            xf = rst_n && in_valid && in_ready;
            if (xf) begin
                issue_q.push_back(in_data);
                result_q.push_back(fir_f(in_data));
            end
            @(posedge clk); #1;
            if (xf) in_data = in_data + 1'b1;
        end
    end

    // FIR core model: result fir_f(din) appears lat cycles after fir_nd.
    int lat = 5;
    logic [15:0] pv = '0;
    logic [DW-1:0] pd [16];
    logic nd_s = 1'b0, mdl_rdy = 1'b0;
    logic [DW-1:0] din_s = '0, mdl_dout = '0;
    always @(negedge clk) begin
        nd_s = fir_nd;
        din_s = fir_din;
    end
    always @(posedge clk) begin
        #1;
        for (int i = 15; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = nd_s;
        pd[0] = fir_f(din_s);
        for (int i = 0; i < 16; i++) if (i >= lat) pv[i] = 1'b0;
        mdl_rdy = pv[lat-1];
        mdl_dout = pd[lat-1];
    end
    assign fir_rdy  = mdl_rdy | stray_rdy;
    assign fir_dout = mdl_dout;

    // Monitor: pops the scoreboard on every issue and every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fir_nd) begin
                nd_cnt++;
                if (issue_q.size() == 0) check("nd_unexpected", issue_q.size(), 1);
                else check("fir_din", fir_din, issue_q.pop_front());
                if (chk_sp && last_nd >= 0) check("nd_spacing", cyc - last_nd, 4);
                last_nd = cyc;
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (result_q.size() == 0) check("out_unexpected", result_q.size(), 1);
                else check("out_data", out_data, result_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_nd(input string nm);
        int i = 0;
        do begin @(negedge clk); i++; end while (!fir_nd && i < 200);
        check(nm, fir_nd, 1);
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while (busy && i < 100) begin step(1); i++; end
        check(nm, busy, 0);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_in_ready"}, in_ready, 1);
        check({p, "_out_valid"}, out_valid, 0);
        check({p, "_out_data"}, out_data, 0);
        check({p, "_fir_nd"}, fir_nd, 0);
        check({p, "_fir_din"}, fir_din, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_missed"}, missed_tick_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int m0, n0, p0;
        logic saw;
        rst_n = 0; enable = 0; in_valid = 1; fir_rfd = 1; out_ready = 1; stray_rdy = 0;
        #12;
        check_reset_vals("rst");
        step(2);
        rst_n = 1;

        // Basic flow: nd every 4 cycles, data in order
        enable = 1;
        wait_nd("basic_nd1");
        wait_nd("basic_nd2");
        step(1);
        chk_sp = 1;
        step(24);
        chk_sp = 0;
        check("basic_missed", missed_tick_cnt, 0);

        // rfd stall for 10 cycles starting right after an issue
        wait_nd("stall_sync");
        step(1);
        fir_rfd = 0; m0 = missed_tick_cnt; n0 = nd_cnt;
        step(10);
        fir_rfd = 1;
        check("stall_no_nd", nd_cnt, n0);
        check("stall_missed", missed_tick_cnt, m0 + 2 * STATS);
        step(1);
        check("rfd_resume_nd", fir_nd, 1);

        // Credit limit
        fir_rfd = 0;
        step(12);
        out_ready = 0; fir_rfd = 1; n0 = nd_cnt;
        step(40);
        check("credit_issues", nd_cnt - n0, 4);
        check("credit_fifo_valid", out_valid, 1);
        out_ready = 1;
        step(1);
        out_ready = 0; n0 = nd_cnt;
        step(20);
        check("credit_one_more", nd_cnt - n0, 1);
        out_ready = 1;
        step(12);

        // Drain with 3 outstanding (long core latency)
        fir_rfd = 0;
        step(12);
        lat = 14; fir_rfd = 1; n0 = nd_cnt; p0 = pop_cnt;
        wait_nd("drain_nd1");
        wait_nd("drain_nd2");
        wait_nd("drain_nd3");
        step(1);
        enable = 0;
        step(1);
        check("drain_busy", busy, 1);
        wait_idle("drain_to_idle");
        step(2);
        check("drain_no_new_nd", nd_cnt - n0, 3);
        check("drain_results", pop_cnt - p0, 3);

        // Issue coinciding with fir_rdy (latency 7, period 4)
        lat = 7; enable = 1;
        repeat (4) wait_nd("simul_warm");
        for (int k = 0; k < 3; k++) begin
            wait_nd("simul_nd");
            check("simul_outstanding", dut.outstanding, 2);
        end

        // Tick coinciding with issue: pending kept, no miss counted
        wait_nd("ti_sync");
        step(1);
        fir_rfd = 0; m0 = missed_tick_cnt;
        step(9);
        fir_rfd = 1;
        step(1);
        check("ti_nd", fir_nd, 1);
        check("ti_pending", dut.pending, 1);
        check("ti_missed", missed_tick_cnt, m0 + STATS);
        step(1);
        check("ti_nd_again", fir_nd, 1);

        // Async reset with 2 outstanding and one FIFO entry
        repeat (4) wait_nd("rst_sync");
        step(1);
        out_ready = 0;
        step(4);
        check("pre_rst_outstanding", dut.outstanding, 2);
        check("pre_rst_fifo_valid", out_valid, 1);
        #2 rst_n = 0;
        #1 check_reset_vals("arst");
        issue_q.delete();
        result_q.delete();
        enable = 0; out_ready = 1;
        step(2);
        rst_n = 1;
        step(1);
        stray_rdy = 1;
        step(1);
        stray_rdy = 0;
        saw = out_valid;
        repeat (12) begin step(1); saw |= out_valid; end
        check("stray_ignored", saw, 0);
        check("post_rst_busy", busy, 0);

        // Recovery run
        lat = 5; enable = 1;
        step(30);
        enable = 0;
        wait_idle("final_idle");
        step(3);
        check("end_issue_q", issue_q.size(), 1);
        check("end_result_q", result_q.size(), 1);
        check("end_missed", missed_tick_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
